counter_capture: RTL

- Downstream consumer of the up/down counter's `count` bus and terminal-count `pulse`.
- Timestamps external capture strobes and counter wrap events with the live count value.
- Buffers the records in a small FIFO and presents them on a valid/ready stream to the reading logic (CPU register block or logger).

---
 rtl/counter_capture_pkg.sv | 18 +
 rtl/capture_fifo.sv | 77 +++++++
 rtl/counter_capture.sv | 84 ++++++++
 3 files changed

// File: rtl/counter_capture_pkg.sv
// Shared definitions for the counter capture block: record layout helpers.
package counter_capture_pkg;

  localparam int TAG_BITS = 2;

  function automatic int rec_width(input int size);
    return size + TAG_BITS;
  endfunction

  function automatic int cap_bit(input int size);
    return size + 1;
  endfunction

  function automatic int wrap_bit(input int size);
    return size;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Generic synchronous FIFO with registered level, sync clear and async reset.
module capture_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is reset here because the head entry is visible on the output and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/counter_capture.sv
// Timestamps capture strobes and counter wraps, queues records on a valid/ready stream.
module counter_capture
  import counter_capture_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int RW = rec_width(SIZE)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] count,
  input  logic            pulse,
  input  logic            capture,
  input  logic            clear,
  output logic [RW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overflow,
  output logic [LW-1:0]   level
);

  localparam int CAP_BIT  = cap_bit(SIZE);
  localparam int WRAP_BIT = wrap_bit(SIZE);

  logic          capture_q, pulse_q;
  logic          overflow_q, overflow_d;
  logic          cap_evt, wrap_evt, evt, pop;
  logic          fifo_full, fifo_empty;
  logic [RW-1:0] record;

  assign cap_evt  = capture & ~capture_q;
  assign wrap_evt = pulse & ~pulse_q;
  assign evt      = cap_evt | wrap_evt;

  always_comb begin
    record             = '0;
    record[SIZE-1:0]   = count;
    record[WRAP_BIT]   = wrap_evt;
    record[CAP_BIT]    = cap_evt;
  end

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // An event is only lost when the FIFO is full and nothing leaves this cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (clear)                          overflow_d = 1'b0;
    else if (evt && fifo_full && !pop)  overflow_d = 1'b1;
  end

  // Edge detectors track their inputs every cycle, clear included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      capture_q  <= 1'b0;
      pulse_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      capture_q  <= capture;
      pulse_q    <= pulse;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  capture_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (clear),
    .push_i  (evt),
    .pop_i   (out_ready),
    .wdata_i (record),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

endmodule
